// File: rtl/demux32_1x4_reg_pkg.sv
// Shared constants for the 1-to-4 registered demultiplexer: default widths,
// channel count, channel indices and the select decoder.
package demux32_1x4_reg_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 16;
   localparam int N_CH      = 4;

   localparam logic [1:0] CH_A = 2'd0;
   localparam logic [1:0] CH_B = 2'd1;
   localparam logic [1:0] CH_C = 2'd2;
   localparam logic [1:0] CH_D = 2'd3;

   function automatic logic [N_CH-1:0] sel_onehot(input logic [1:0] sel);
      logic [N_CH-1:0] oh;
      case (sel)
         CH_A:    oh = 4'b0001;
         CH_B:    oh = 4'b0010;
         CH_C:    oh = 4'b0100;
         CH_D:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: holding register, valid flag and delivery counter.
// A slot reports itself free when empty or when its word leaves this cycle.
module demux_slot
   import demux32_1x4_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   input  logic             i_cnt_clr,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_free
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             w_take;

   assign w_take  = r_valid & i_ready;
   assign o_free  = ~r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_cnt   = r_cnt;

   // Word storage: a reload in the delivery cycle keeps the slot full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (w_take) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Delivery counter: clear has priority over a coincident handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_cnt_clr) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (w_take) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/demux32_1x4_reg.sv
// Registered 1-to-4 demultiplexer with broadcast and per-channel delivery
// counters. This level only decodes the target and computes in_ready.
module demux32_1x4_reg
   import demux32_1x4_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [1:0]            in_sel,
   input  logic                  in_bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [N_CH*WIDTH-1:0] out_data,
   output logic [N_CH-1:0]       out_valid,
   input  logic [N_CH-1:0]       out_ready,
   input  logic                  cnt_clr,
   output logic [N_CH*CNT_W-1:0] out_cnt
);

   logic [N_CH-1:0] w_free;
   logic [N_CH-1:0] w_target;
   logic [N_CH-1:0] w_load;
   logic            w_accept;

   // Target decode and readiness: every targeted slot must be free, so a
   // broadcast is taken only when all four can load together.
   always_comb begin
      w_target = {N_CH{1'b0}};
      if (in_bcast) begin
         w_target = {N_CH{1'b1}};
      end else begin
         w_target = sel_onehot(in_sel);
      end
      in_ready = &(w_free | ~w_target);
      w_accept = in_valid & in_ready;
      w_load   = w_target & {N_CH{w_accept}};
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_load    (w_load[g]),
         .i_data    (in_data),
         .i_ready   (out_ready[g]),
         .i_cnt_clr (cnt_clr),
         .o_valid   (out_valid[g]),
         .o_data    (out_data[g*WIDTH +: WIDTH]),
         .o_cnt     (out_cnt[g*CNT_W +: CNT_W]),
         .o_free    (w_free[g])
      );
   end

endmodule

// File: doc/demux32_1x4_reg.md
DEMUX32_1X4_REG -- requirements
Module: demux32_1x4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of input and of each output channel.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel delivery counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  word to distribute.
REQ-006 SHALL have port in_sel  input  2  target channel 0..3 (0=A, 1=B, 2=C, 3=D).
REQ-007 SHALL have port in_bcast  input  1  1 = write word to all four channels; in_sel ignored.
REQ-008 SHALL have port in_valid  input  1  producer offers in_data/in_sel/in_bcast.
REQ-009 SHALL have port in_ready  output  1  block accepts offer this cycle.
REQ-010 SHALL have port out_data  output  4*WIDTH  packed channel words, channel i at [i*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  4  per-channel holding register full.
REQ-012 SHALL have port out_ready  input  4  per-channel consumer takes word.
REQ-013 SHALL have port cnt_clr  input  1  synchronous clear of all delivery counters.
REQ-014 SHALL have port out_cnt  output  4*CNT_W  packed per-channel delivery counters.

Function
REQ-015 SHALL hold one word per channel in a holding register (slot); slot i "free" = ~out_valid[i] | out_ready[i].
REQ-016 SHALL drive in_ready = (in_bcast ? all four slots free : slot[in_sel] free), combinationally from out_valid/out_ready.
REQ-017 SHALL define accept = in_valid & in_ready; on accept, target slot(s) load in_data and set out_valid on the next edge (latency 1 cycle).
REQ-018 SHALL clear out_valid[i] on out_valid[i] & out_ready[i] unless slot i is reloaded the same cycle, in which case out_valid[i] stays 1 with the new word (back-to-back, full throughput per channel).
REQ-019 SHALL keep out_data[i] stable while out_valid[i] & ~out_ready[i]; non-target slots are never modified by an accept.
REQ-020 SHALL, on broadcast accept, load all four slots in the same cycle; a broadcast is never partially applied.
REQ-021 SHALL leave in_ready meaningful when in_valid = 0 (no dependency on in_valid).
REQ-022 SHALL increment out_cnt[i] by 1 on every out_valid[i] & out_ready[i], wrapping 2^CNT_W-1 -> 0.
REQ-023 SHALL, when cnt_clr coincides with a handshake, set the counter to 0 (clear wins).
REQ-024 SHALL treat out_ready[i] asserted with out_valid[i] = 0 as no-op (no count, no state change).

Reset
REQ-025 SHALL, on rst_n low, immediately force out_valid = 0, out_data = 0, out_cnt = 0, independent of clk.
REQ-026 SHALL discard any held, undelivered words on reset mid-operation; first accept after rst_n rises behaves as from power-up.
REQ-027 SHALL release reset synchronously usable: first accept possible on the first rising edge with rst_n high.

Structure
REQ-028 SHALL place WIDTH default, CNT_W default, channel count (4) and channel index constants (CH_A..CH_D) in the shared CPU package.
REQ-029 SHALL implement each channel as one instance of sub-module demux_slot (holding register, valid flag, delivery counter), four instances total; top level holds select decode and in_ready logic only.

Verification
REQ-030 SHALL cover: reset, in_sel=2, in_data=0x1234_5678, out_ready=4'b0100 -> out_valid=4'b0100 one cycle later, channel C = 0x1234_5678, out_cnt C = 1 after handshake.
REQ-031 SHALL cover: channel B full, out_ready[1]=0, offer in_sel=1 -> in_ready=0, B word unchanged for 10 cycles; raise out_ready[1] -> accept same cycle, B reloads with no bubble.
REQ-032 SHALL cover: in_bcast=1, data 0xDEAD_BEEF, channel D full and stalled -> in_ready=0, no slot written; release D -> all four slots = 0xDEAD_BEEF same cycle.
REQ-033 SHALL cover: continuous stream to channel A with out_ready[0]=1, 8 words -> 8 deliveries in 8 consecutive cycles, out_cnt A = 8.
REQ-034 SHALL cover: preload counter A to 0xFFFF via 65535 deliveries, one more -> 0x0000; cnt_clr coinciding with handshake -> 0.
REQ-035 SHALL cover: rst_n pulsed low mid-stream with channels A and C full -> out_valid=0, out_data=0, out_cnt=0 asynchronously, before next clk edge.
